// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// FSM encoding and the baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Read data is registered and valid the cycle after a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] rdata_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign rdata_o = rdata_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_pop) rdata_q <= mem_q[rd_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first.
// A FIFO feeds a serialiser that sends frames back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 80000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [7:0]                    i_Data,
  input  logic                          i_Write,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Busy,
  output logic                          o_TX
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shf_q;
  logic [2:0]    idx_q;
  logic          tx_q;
  logic          busy_q;
  logic          ld_q;

  logic          pop;
  logic          bit_end;
  logic [7:0]    rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Reset_n),
    .push_i  (i_Write),
    .wdata_i (i_Data),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (o_Full),
    .empty_o (o_Empty),
    .count_o (o_Count)
  );

  // Pop one cycle before the byte is needed: FIFO read data is registered.
  assign pop = !o_Empty && !ld_q &&
               ((state_q == IDLE) ||
                (state_q == STOP && cnt_q == PRE));

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shf_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      if (pop) ld_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (ld_q) begin
            shf_q   <= rdata;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ld_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shf_q[0];
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= shf_q[1];
              shf_q <= {1'b0, shf_q[7:1]};
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (ld_q) begin
              shf_q   <= rdata;
              tx_q    <= 1'b0;
              ld_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_TX   = tx_q;
  assign o_Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a scoreboard
// and a reference 8N1 receiver model.
module tb_uart_tx_buffered;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int DIV    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic       wr = 1'b0;
  logic       full, empty, busy, tx;
  logic [4:0] count;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .i_Data    (data),
    .i_Write   (wr),
    .o_Full    (full),
    .o_Empty   (empty),
    .o_Count   (count),
    .o_Busy    (busy),
    .o_TX      (tx)
  );

  int         tests = 0;
  int         fails = 0;
  int         acc = 0;
  int         drops = 0;
  int         rxn = 0;
  bit         rx_abort = 1'b0;
  logic [7:0] sb [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Drive one push; returns at the negedge after it is sampled.
  task automatic push(input logic [7:0] b);
    data = b;
    wr = 1'b1;
    if (!full) begin
      sb.push_back(b);
      acc++;
    end else begin
      drops++;
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || !empty) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n < 20000), 1);
  endtask

  // Reference receiver: samples mid-bit on negedges.
  initial begin : rx_model
    logic [7:0] b;
    logic       s;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        rx_abort = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        s = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (!rx_abort) begin
          chk("rx_start", 32'(s), 0);
          chk("rx_stop", 32'(tx), 1);
          chk("rx_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) chk("rx_byte", 32'(b), 32'(sb.pop_front()));
          rxn++;
        end
      end
    end
  end

  initial begin
    int n;
    int lows;
    logic [7:0] v;
    logic       etx;
    v = 8'h55;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: exact waveform relative to the push edge
    push(v);
    for (int j = 0; j < 106; j++) begin
      if (j < 2)       etx = 1'b1;
      else if (j < 12) etx = 1'b0;
      else if (j < 92) etx = v[(j - 12) / 10];
      else             etx = 1'b1;
      chk("t1_tx", 32'(tx), 32'(etx));
      chk("t1_busy", 32'(busy), 32'(j >= 2 && j < 102));
      @(negedge clk);
    end
    wait_idle("t1");

    // Back-to-back frames
    push(8'hA5);
    push(8'h00);
    push(8'hFF);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t2_busy_len", 32'(n), 300);
    wait_idle("t2");

    // Fill while transmitting, then push-while-full during a pop
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(count), 16);
    push(8'h77);
    chk("t3_drop_count", 32'(count), 16);
    n = 0;
    while (full && n < 200) begin
      chk("t4_count16", 32'(count), 16);
      push(8'hEE);
      n++;
    end
    chk("t4_count_after_pop", 32'(count), 15);
    chk("t4_full_after_pop", 32'(full), 0);
    wait_idle("t3");

    // Reset during data bit 3 with four bytes queued
    push(8'h3C);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_seen", 32'(n < 20), 1);
    repeat (45) @(negedge clk);
    chk("t5_count_pre", 32'(count), 4);
    #1;
    rx_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_tx", 32'(tx), 1);
    chk("t5_count", 32'(count), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_empty", 32'(empty), 1);
    acc = acc - sb.size();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("t5_quiet", 32'(lows), 0);
    push(8'h5A);
    wait_idle("t5");

    // Random stream with random gaps
    for (int i = 0; i < 200; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    wait_idle("t6");
    chk("t6_rx_count", 32'(rxn), 32'(acc));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
